display_frame_scheduler: RTL and testbench

- Shares the 5x7 LED matrix column-scan displayer between up to NUM_SRC image requesters, e.g. game field, score and text banner.
- Grants one requester at a time using round-robin.
- Holds each grant for a minimum number of complete scan frames.
- Latches the granted 35-bit image only on frame boundaries, so the displayer never shows a torn frame. Output feeds the displayer's image input directly.

---
 rtl/display_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/display_frame_scheduler.sv | 175 +++++++++++++++++
 tb/tb_display_frame_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 5x7 LED matrix display path.
//   COLUNE_SIZE / TOTAL_COLUNES : matrix geometry (rows per column, columns)
//   DATA_WIDTH                  : packed image width (one bit per LED)
//   sched_state_e               : frame scheduler state encoding
//   BLANK_IMAGE                 : all-LEDs-off image
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int COLUNE_SIZE   = 7;
    localparam int TOTAL_COLUNES = 5;
    localparam int DATA_WIDTH    = COLUNE_SIZE * TOTAL_COLUNES;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } sched_state_e;

    localparam logic [DATA_WIDTH-1:0] BLANK_IMAGE = '0;

endpackage : display_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first eligible request at or
// after rr_ptr, wrapping from NUM_SRC-1 back to 0. A request is eligible when
// its req bit is set and its exclude bit is clear.
// Ports:
//   req     [NUM_SRC]  request levels
//   rr_ptr  [SRC_W]    search start index (expected < NUM_SRC)
//   exclude [NUM_SRC]  sources to skip (e.g. the current owner)
//   gnt     [NUM_SRC]  one-hot candidate, zero when nothing eligible
//   gnt_idx [SRC_W]    index of the candidate, zero when nothing eligible
//   valid              at least one eligible request
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 3
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    input  logic [NUM_SRC-1:0] exclude,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               valid
);

    logic [NUM_SRC-1:0]   eligible;
    logic [2*NUM_SRC-1:0] rot_dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [NUM_SRC-1:0]   first_rot;
    logic [2*NUM_SRC-1:0] gnt_dbl;

    assign eligible = req & ~exclude;

    // Rotate so that rr_ptr lands on bit 0; the lowest set bit of the rotated
    // vector is then the round-robin winner.
    assign rot_dbl = {eligible, eligible} >> rr_ptr;
    assign rot     = rot_dbl[NUM_SRC-1:0];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_rot[gi] = rot[gi];
            end else begin : g_rest
                assign first_rot[gi] = rot[gi] & ~(|rot[gi-1:0]);
            end
        end
    endgenerate

    // Undo the rotation: the wrapped part of the shift folds back from the
    // upper half.
    assign gnt_dbl = {{NUM_SRC{1'b0}}, first_rot} << rr_ptr;
    assign gnt     = gnt_dbl[NUM_SRC-1:0] | gnt_dbl[2*NUM_SRC-1:NUM_SRC];
    assign valid   = |eligible;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                gnt_idx = gnt_idx | SRC_W'(i);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/display_frame_scheduler.sv
// ---------------------------------------------------------------------------
// display_frame_scheduler
// Shares the LED matrix displayer between NUM_SRC image requesters. One
// requester owns the display at a time (round-robin), ownership is kept for at
// least HOLD_FRAMES scan frames while others wait, and the owner's image is
// latched only on frame_tick so the displayer never shows a torn frame.
// Optional build macro: FRAME_SCHED_PRIORITY_EN -- source 0 preempts any other
// owner at the next tick and is never displaced by hold expiry; its grants do
// not move the round-robin pointer.
// Ports:
//   clk         system clock (shared with the displayer)
//   reset       asynchronous active-low reset
//   frame_tick  one-cycle pulse at the end of each full column scan
//   req         per-source request levels
//   image_in    source i image in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   grant       one-hot current owner, zero when idle
//   image_out   frame-latched image for the displayer
//   owner       index of the current owner, zero when idle
//   busy        high while a source owns the display
// ---------------------------------------------------------------------------
module display_frame_scheduler #(
    parameter int DATA_WIDTH  = 35,
    parameter int NUM_SRC     = 4,
    parameter int HOLD_FRAMES = 8,
    parameter int SRC_W       = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [NUM_SRC-1:0]            req,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] image_in,
    output logic [NUM_SRC-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         image_out,
    output logic [SRC_W-1:0]              owner,
    output logic                          busy
);

    import display_pkg::*;

    localparam logic [7:0]            HOLD_RELOAD = 8'(HOLD_FRAMES - 1);
    localparam logic [DATA_WIDTH-1:0] BLANK       = DATA_WIDTH'(BLANK_IMAGE);
    localparam logic [NUM_SRC-1:0]    SRC0_GNT    = NUM_SRC'(1);

    sched_state_e              state_q,  state_d;
    logic [NUM_SRC-1:0]        grant_q,  grant_d;
    logic [SRC_W-1:0]          owner_q,  owner_d;
    logic [7:0]                hold_q,   hold_d;
    logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]     image_q,  image_d;

    logic [NUM_SRC-1:0]        arb_gnt;
    logic [SRC_W-1:0]          arb_idx;
    logic                      arb_valid;

    logic [DATA_WIDTH-1:0]     src_image   [NUM_SRC];
    logic [DATA_WIDTH-1:0]     arb_masked  [NUM_SRC];
    logic [DATA_WIDTH-1:0]     own_masked  [NUM_SRC];
    logic [DATA_WIDTH-1:0]     arb_image;
    logic [DATA_WIDTH-1:0]     owner_image;

    logic                      owner_req;
    logic                      may_switch;
    logic                      prio_take;
    logic                      prio_hold;
    logic [SRC_W-1:0]          rr_after_arb;

    // The current owner is excluded so a hold-expiry switch moves on to a
    // different source; in IDLE grant_q is zero and nothing is excluded.
    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .exclude (grant_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_image[gi]  = image_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign arb_masked[gi] = {DATA_WIDTH{arb_gnt[gi]}} & src_image[gi];
            assign own_masked[gi] = {DATA_WIDTH{grant_q[gi]}} & src_image[gi];
        end
    endgenerate

    // One-hot AND-OR image selection for the candidate and the current owner.
    always_comb begin
        arb_image   = '0;
        owner_image = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            arb_image   = arb_image   | arb_masked[i];
            owner_image = owner_image | own_masked[i];
        end
    end

    assign owner_req    = |(req & grant_q);
    assign rr_after_arb = (arb_idx == SRC_W'(NUM_SRC - 1)) ? '0 : arb_idx + 1'b1;

`ifdef FRAME_SCHED_PRIORITY_EN
    assign prio_take = req[0] && ((state_q == IDLE) || (owner_q != '0));
    assign prio_hold = req[0] && (state_q == ACTIVE) && (owner_q == '0);
`else
    assign prio_take = 1'b0;
    assign prio_hold = 1'b0;
`endif

    // A new round-robin grant is allowed from IDLE, when the owner lets go,
    // or once the minimum hold has run out.
    assign may_switch = (state_q == IDLE) || !owner_req ||
                        ((hold_q == 8'd0) && !prio_hold);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        rr_ptr_d = rr_ptr_q;
        image_d  = image_q;
        if (frame_tick) begin
            if (prio_take) begin
                // Priority grant leaves rr_ptr alone so rotation resumes later.
                state_d = ACTIVE;
                grant_d = SRC0_GNT;
                owner_d = '0;
                hold_d  = HOLD_RELOAD;
                image_d = src_image[0];
            end else if (may_switch && arb_valid) begin
                state_d  = ACTIVE;
                grant_d  = arb_gnt;
                owner_d  = arb_idx;
                hold_d   = HOLD_RELOAD;
                rr_ptr_d = rr_after_arb;
                image_d  = arb_image;
            end else if ((state_q == IDLE) || !owner_req) begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                hold_d  = 8'd0;
                image_d = BLANK;
            end else begin
                // Keep the owner; hold_cnt saturates at zero so a sole owner
                // can be displaced at the very next tick once anyone asks.
                image_d = owner_image;
                hold_d  = (hold_q == 8'd0) ? 8'd0 : hold_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            hold_q   <= 8'd0;
            rr_ptr_q <= '0;
            image_q  <= BLANK;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
            image_q  <= image_d;
        end
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign image_out = image_q;
    assign busy      = (state_q == ACTIVE);

endmodule : display_frame_scheduler

// File: tb/tb_display_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_display_frame_scheduler
// Directed stimulus for display_frame_scheduler (default build, HOLD_FRAMES=2).
// The stimulus pushes the expected outputs for every frame_tick (or explicit
// observation point) into a queue; a monitor pops and compares one cycle
// after each such event.
// ---------------------------------------------------------------------------
module tb_display_frame_scheduler;

    localparam int DW = 35;
    localparam int NS = 4;
    localparam int SW = 3;
    localparam int HF = 2;

    localparam logic [DW-1:0] I0   = 35'h0_1111_1111;
    localparam logic [DW-1:0] I1   = 35'h2_2222_2222;
    localparam logic [DW-1:0] I2   = 35'h1_2345_6789;
    localparam logic [DW-1:0] I3   = 35'h4_4444_4444;
    localparam logic [DW-1:0] INEW = 35'h7_0000_0001;

    logic              clk        = 1'b0;
    logic              reset      = 1'b0;
    logic              frame_tick = 1'b0;
    logic              chk_strobe = 1'b0;
    logic [NS-1:0]     req        = '0;
    logic [NS*DW-1:0]  image_in   = '0;
    logic [NS-1:0]     grant;
    logic [DW-1:0]     image_out;
    logic [SW-1:0]     owner;
    logic              busy;

    typedef struct {
        string         name;
        logic [NS-1:0] g;
        logic [SW-1:0] o;
        logic [DW-1:0] img;
        logic          b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic obs_q = 1'b0;

    display_frame_scheduler #(
        .DATA_WIDTH  (DW),
        .NUM_SRC     (NS),
        .HOLD_FRAMES (HF),
        .SRC_W       (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .req        (req),
        .image_in   (image_in),
        .grant      (grant),
        .image_out  (image_out),
        .owner      (owner),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Observation request: a tick (or explicit check) seen on this posedge is
    // compared at the following negedge.
    always @(posedge clk) obs_q <= frame_tick | chk_strobe;

    always @(negedge clk) begin
        exp_t e;
        if (obs_q) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL no_expectation: got grant=%b owner=%0d image=%h busy=%b",
                         grant, owner, image_out, busy);
            end else begin
                e = exp_q.pop_front();
                if (grant !== e.g || owner !== e.o || image_out !== e.img || busy !== e.b) begin
                    n_err++;
                    $display("FAIL %s: got grant=%b owner=%0d image=%h busy=%b, expected grant=%b owner=%0d image=%h busy=%b",
                             e.name, grant, owner, image_out, busy, e.g, e.o, e.img, e.b);
                end else begin
                    $display("[%0t] %s: grant=%b owner=%0d image=%h busy=%b ok",
                             $time, e.name, grant, owner, image_out, busy);
                end
            end
        end
    end

    task automatic set_img(input int i, input logic [DW-1:0] v);
        image_in[i*DW +: DW] = v;
    endtask

    task automatic push(input string nm, input logic [NS-1:0] g, input logic [SW-1:0] o,
                        input logic [DW-1:0] img, input logic b);
        exp_t e;
        e.name = nm;
        e.g    = g;
        e.o    = o;
        e.img  = img;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    // One frame: tick for one cycle, then two quiet cycles.
    task automatic tick(input string nm, input logic [NS-1:0] g, input logic [SW-1:0] o,
                        input logic [DW-1:0] img, input logic b);
        @(negedge clk);
        frame_tick = 1'b1;
        push(nm, g, o, img, b);
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    // Compare outputs one cycle later without issuing a tick.
    task automatic observe(input string nm, input logic [NS-1:0] g, input logic [SW-1:0] o,
                           input logic [DW-1:0] img, input logic b);
        @(negedge clk);
        chk_strobe = 1'b1;
        push(nm, g, o, img, b);
        @(negedge clk);
        chk_strobe = 1'b0;
    endtask

    // Reset pulse entirely between clock edges: only an asynchronous reset
    // clears the outputs.
    task automatic reset_pulse();
        @(negedge clk);
        chk_strobe = 1'b1;
        push("async_reset", '0, '0, '0, 1'b0);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        chk_strobe = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got queue depth %0d, expected 0",
                 exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        set_img(0, I0);
        set_img(1, I1);
        set_img(2, I2);
        set_img(3, I3);

        // Reset state and idle with no requests.
        repeat (2) @(negedge clk);
        observe("reset_state", '0, '0, '0, 1'b0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick("idle_noreq", '0, '0, '0, 1'b0);

        // Single requester and frame-latched image.
        req = 4'b0100;
        tick("single_grant", 4'b0100, 3'd2, I2, 1'b1);
        set_img(2, INEW);
        observe("midframe_stable", 4'b0100, 3'd2, I2, 1'b1);
        tick("relatch_new", 4'b0100, 3'd2, INEW, 1'b1);
        set_img(2, I2);

        // Asynchronous reset mid-operation also resets rr_ptr to 0.
        reset_pulse();

        // Round-robin with HOLD_FRAMES=2: 0,0,1,1,3,3,0.
        req = 4'b1011;
        tick("rr_0a", 4'b0001, 3'd0, I0, 1'b1);
        tick("rr_0b", 4'b0001, 3'd0, I0, 1'b1);
        tick("rr_1a", 4'b0010, 3'd1, I1, 1'b1);
        tick("rr_1b", 4'b0010, 3'd1, I1, 1'b1);
        tick("rr_3a", 4'b1000, 3'd3, I3, 1'b1);
        tick("rr_3b", 4'b1000, 3'd3, I3, 1'b1);
        tick("rr_0c", 4'b0001, 3'd0, I0, 1'b1);

        // Bring ownership to source 1, then release with handoff to 3.
        req = 4'b0011;
        tick("keep_0", 4'b0001, 3'd0, I0, 1'b1);
        tick("to_1", 4'b0010, 3'd1, I1, 1'b1);
        req = 4'b1000;
        tick("handoff_3", 4'b1000, 3'd3, I3, 1'b1);
        req = 4'b0000;
        tick("all_drop", '0, '0, '0, 1'b0);

        // Sole owner persistence, then a newcomer is served immediately.
        req = 4'b0001;
        for (int k = 0; k < 20; k++) tick("sole_0", 4'b0001, 3'd0, I0, 1'b1);
        req = 4'b0101;
        tick("new_2", 4'b0100, 3'd2, I2, 1'b1);
        tick("keep_2", 4'b0100, 3'd2, I2, 1'b1);
        tick("wrap_0", 4'b0001, 3'd0, I0, 1'b1);
        req = 4'b0000;
        tick("final_idle", '0, '0, '0, 1'b0);

        // Every pushed expectation must have been consumed.
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_display_frame_scheduler
